// File: rtl/display_arbiter.sv
// +----------------------------------------------------------------------+
// | display_arbiter: shares a 7-seg code between sensor and alarm owners |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module display_arbiter #(
  parameter int HOLD_CYCLES  = 1000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oc_req,
  input  logic       sens_valid,
  input  logic [2:0] sens_code,
  output logic       sens_ack,
  output logic [3:0] number,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SENSOR    = 2'd1,
    S_ALARM_ON  = 2'd2,
    S_ALARM_OFF = 2'd3
  } state_t;

  localparam logic [23:0] C_HOLD_LOAD  = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] C_BLINK_LOAD = 24'(BLINK_CYCLES - 1);
  localparam logic [1:0]  C_GNT_NONE   = 2'b00;
  localparam logic [1:0]  C_GNT_SENS   = 2'b01;
  localparam logic [1:0]  C_GNT_ALARM  = 2'b10;
  localparam logic [3:0]  C_NUM_ALARM  = 4'b0001;
  localparam logic [3:0]  C_NUM_BLANK  = 4'b0000;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_tmr, w_tmr_nxt;
  logic [3:0]  r_number, w_number_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic        r_ack, w_ack_nxt;
  logic        w_tmr_zero;
  logic        w_can_accept;

  assign w_tmr_zero = (r_tmr == 24'd0);

  // The ack cycle itself blocks acceptance so a still-high valid is not taken twice.
  assign w_can_accept = ((r_state == S_IDLE) || ((r_state == S_SENSOR) && w_tmr_zero))
                        && sens_valid && !r_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmr    <= 24'd0;
      r_number <= C_NUM_BLANK;
      r_grant  <= C_GNT_NONE;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tmr    <= w_tmr_nxt;
      r_number <= w_number_nxt;
      r_grant  <= w_grant_nxt;
      r_ack    <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_nxt    = r_tmr;
    w_number_nxt = r_number;
    w_grant_nxt  = r_grant;
    w_ack_nxt    = 1'b0;

    case (r_state)
      S_IDLE, S_SENSOR: begin
        if (oc_req) begin
          w_state_nxt  = S_ALARM_ON;
          w_number_nxt = C_NUM_ALARM;
          w_grant_nxt  = C_GNT_ALARM;
          w_tmr_nxt    = C_BLINK_LOAD;
        end else if (w_can_accept) begin
          w_ack_nxt = 1'b1;
          w_tmr_nxt = C_HOLD_LOAD;
          if (sens_code != 3'b000) begin
            w_state_nxt  = S_SENSOR;
            w_number_nxt = {sens_code, 1'b0};
            w_grant_nxt  = C_GNT_SENS;
          end else begin
            // An all-off code releases the display rather than holding a blank.
            w_state_nxt  = S_IDLE;
            w_number_nxt = C_NUM_BLANK;
            w_grant_nxt  = C_GNT_NONE;
          end
        end else if ((r_state == S_SENSOR) && !w_tmr_zero) begin
          w_tmr_nxt = r_tmr - 24'd1;
        end
      end

      S_ALARM_ON: begin
        if (w_tmr_zero) begin
          w_state_nxt  = S_ALARM_OFF;
          w_number_nxt = C_NUM_BLANK;
          w_tmr_nxt    = C_BLINK_LOAD;
        end else begin
          w_tmr_nxt = r_tmr - 24'd1;
        end
      end

      S_ALARM_OFF: begin
        if (!w_tmr_zero) begin
          w_tmr_nxt = r_tmr - 24'd1;
        end else if (oc_req) begin
          w_state_nxt  = S_ALARM_ON;
          w_number_nxt = C_NUM_ALARM;
          w_tmr_nxt    = C_BLINK_LOAD;
        end else begin
          w_state_nxt  = S_IDLE;
          w_number_nxt = C_NUM_BLANK;
          w_grant_nxt  = C_GNT_NONE;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_number_nxt = C_NUM_BLANK;
        w_grant_nxt  = C_GNT_NONE;
        w_tmr_nxt    = 24'd0;
      end
    endcase
  end

  assign sens_ack = r_ack;
  assign number   = r_number;
  assign grant    = r_grant;

endmodule

`default_nettype wire

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000000, minimum cycles a sensor code is displayed before replacement; legal range 1..2^24-1.
REQ-002 Parameter BLINK_CYCLES, default 12500000, length of each alarm on/off phase in cycles; legal range 1..2^24-1.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 oc_req  input  1  overcurrent alarm request, level-sensitive.
REQ-006 sens_valid  input  1  sensor requester has a code pending; held high until sens_ack.
REQ-007 sens_code  input  3  {L,C,R} position flags; sampled only when accepted.
REQ-008 sens_ack  output  1  one-cycle pulse when sens_code has been accepted.
REQ-009 number  output  4  code to seven-segment driver, {L,C,R,O}.
REQ-010 grant  output  2  current owner of the display: 00 none, 01 sensor, 10 alarm; 11 never driven.

Function
REQ-011 The block SHALL implement four states: IDLE, SENSOR, ALARM_ON and ALARM_OFF.
REQ-012 The block SHALL register all outputs, with no combinational path from input to output.
REQ-013 The block SHALL use a single 24-bit down-counter, tmr, shared by the hold and blink timing.
REQ-014 A sensor code SHALL be accepted on an edge where state is IDLE, or SENSOR with tmr==0, and sens_valid=1, oc_req=0 and sens_ack=0.
REQ-015 On acceptance, at that same edge: number<={sens_code,1'b0}, sens_ack<=1 for exactly one cycle, tmr<=HOLD_CYCLES-1.
REQ-016 On acceptance of a nonzero sens_code, the next state SHALL be SENSOR with grant<=01.
REQ-017 On acceptance of sens_code==000, the next state SHALL be IDLE with number<=0000 and grant<=00; this is still acknowledged.
REQ-018 In SENSOR, tmr SHALL decrement each cycle while nonzero.
REQ-019 In SENSOR with tmr==0 and no request pending, state, number and grant SHALL hold indefinitely.
REQ-020 A sens_valid seen during the sens_ack cycle SHALL be ignored, so no double acceptance occurs.
REQ-021 oc_req=1 SHALL preempt IDLE or SENSOR at the next edge regardless of tmr: state<=ALARM_ON, number<=0001, grant<=10, tmr<=BLINK_CYCLES-1.
REQ-022 Any pending sensor request SHALL remain unacknowledged during preemption.
REQ-023 In ALARM_ON and ALARM_OFF, tmr SHALL decrement each cycle.
REQ-024 At ALARM_ON with tmr==0: go to ALARM_OFF, number<=0000, tmr<=BLINK_CYCLES-1.
REQ-025 At ALARM_OFF with tmr==0 and oc_req=1: go to ALARM_ON, number<=0001, tmr<=BLINK_CYCLES-1.
REQ-026 At ALARM_OFF with tmr==0 and oc_req=0: go to IDLE, number<=0000, grant<=00.
REQ-027 A phase in progress SHALL always complete; dropping oc_req mid-phase has no immediate effect.
REQ-028 Sensor requests SHALL NOT be accepted in any alarm state.
REQ-029 A request still pending on return to IDLE SHALL be accepted one edge after IDLE is entered, if oc_req=0.
REQ-030 If oc_req and sens_valid are both high at an acceptance edge, the alarm SHALL win and no sens_ack is issued.
REQ-031 Back-to-back sensor codes SHALL each be displayed for at least HOLD_CYCLES cycles, unless an alarm preempts.

Reset
REQ-032 While rst=1 at an edge: state<=IDLE, tmr<=0, number<=0000, grant<=00, sens_ack<=0.
REQ-033 rst SHALL override every other condition, including mid-alarm, mid-hold and an ack cycle.
REQ-034 A sensor request held across reset SHALL be accepted no earlier than the first edge with rst=0.

Verification (HOLD_CYCLES=4, BLINK_CYCLES=3)
REQ-035 Sensor accept: reset, then sens_valid=1, sens_code=100 -> one cycle later number=1000, grant=01, sens_ack high for 1 cycle; drop valid -> number stays 1000.
REQ-036 Hold enforcement: code 100 accepted, new code 001 presented the next cycle -> ack and number=0010 exactly 4 cycles after the first acceptance edge.
REQ-037 Preemption: in SENSOR with tmr=3, raise oc_req -> next cycle number=0001, grant=10; then 3 cycles 0001, 3 cycles 0000, repeating while oc_req=1.
REQ-038 Alarm exit with pending sensor: drop oc_req mid-ALARM_ON while sens_valid=1, code=010 -> phase completes, ALARM_OFF 3 cycles, IDLE 1 cycle, then number=0100 with ack.
REQ-039 Simultaneous requests: from IDLE, oc_req=1 and sens_valid=1 on the same edge -> grant=10, no sens_ack for the whole alarm.
REQ-040 Reset mid-operation: assert rst for 1 cycle during ALARM_OFF -> next cycle number=0000, grant=00, sens_ack=0; resumes normally after release.
